ysyx_23060025_csr_file: RTL and testbench
=========================================

Name: ysyx_23060025_csr_file

Overview:
Parametrised M-mode CSR file that replaces the fixed-register CSR block.
- Adds CSRRW/CSRRS/CSRRC semantics, trap entry and MRET sequencing, a live mstatus (MIE/MPIE), mie/mip timer-interrupt gating, mscratch and a 64-bit mcycle counter.
- Sits beside the register file in EXU/WBU; supplies the trap/return redirect target to IFU.

Parameters:
- DATA_WIDTH, 32, CSR data width; only 32 is supported.
- MCYCLE_EN, 1, 1 = mcycle/mcycleh implemented; 0 = both read 0 and are illegal to write.
- MVENDORID_VAL, 32'h79737978, mvendorid constant.
- MARCHID_VAL, 32'd23060025, marchid constant.
- MTVEC_RST, 32'h0, mtvec reset value.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- csr_addr  in  12  CSR address, shared by read and write
- csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC
- csr_wdata  in  32  rs1 or zimm operand
- csr_rdata  out  32  current value at csr_addr (combinational, pre-write)
- csr_illegal  out  1  access to an unimplemented CSR, or a write to a read-only CSR
- trap_valid  in  1  take trap this cycle
- trap_cause  in  32  mcause value for the trap
- trap_pc  in  32  faulting/next PC, saved to mepc
- mret_valid  in  1  execute MRET this cycle
- irq_timer  in  1  external machine timer level (CLINT)
- irq_pending  out  1  MIE & mie.MTIE & irq_timer
- redirect_valid  out  1  trap_valid | mret_valid
- redirect_pc  out  32  trap: {mtvec[31:2],2'b00}; mret: mepc (combinational)

Behaviour:
Reset:
- Asynchronous, active-high; values apply immediately on assertion.
- mstatus = 32'h1800 (MPP = 11, MIE = 0, MPIE = 0); mtvec = MTVEC_RST; mepc, mcause, mscratch, mie, mcycle = 0.
- Outputs during reset follow the combinational rules from these values: irq_pending = 0, redirect_valid = trap_valid | mret_valid.

Read:
- csr_rdata is combinational from csr_addr and returns the old value in a write cycle.
- Unimplemented address returns 0 with csr_illegal = 1 whenever csr_op != 00.

Write (takes effect at the next rising clock edge):
- RW: new = wdata. RS: new = old | wdata. RC: new = old & ~wdata.
- RS or RC with wdata == 0 performs no write and never flags illegal on a read-only CSR.
- Read-only CSRs: mvendorid, marchid, mip. A write attempt sets csr_illegal and leaves state unchanged.

Field rules:
- mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] is hardwired 11; all other bits read 0.
- mie: only MTIE[7] is writable.
- mip: MTIP[7] = irq_timer, not stored.
- mtvec: bits [1:0] read 0 (direct mode only).
- mepc: bits [1:0] are forced 0 on every write and on trap save.
- mcycle/mcycleh:
  - Increment by 1 every cycle, with carry from low word into high word.
  - A software write to either half replaces that half for that cycle and suppresses the increment.
  - Low = FFFF_FFFF wraps to 0 with high + 1; full 64-bit wrap goes to 0.

Trap (trap_valid = 1), at the edge:
- mepc <= trap_pc & ~3; mcause <= trap_cause; MPIE <= MIE; MIE <= 0.

MRET (mret_valid = 1), at the edge:
- MIE <= MPIE; MPIE <= 1.

Simultaneous events:
- Priority is trap > mret > CSR write. A CSR write in a trap or mret cycle is dropped; csr_rdata is still driven.
- trap_valid together with mret_valid: only the trap is taken, and redirect_pc = mtvec.

Latency:
- Redirect is same-cycle, combinational.
- State updates are visible one cycle later.

Decomposition:
- Shared define/package file ysyx_23060025_define.v holds:
  - CSR addresses: mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mip 344, mcycle B00, mcycleh B80, mvendorid F11, marchid F12.
  - CSR_OP_* encodings.
  - Bit positions MIE = 3, MPIE = 7, MTIE/MTIP = 7.
- One sub-module, ysyx_23060025_csr_cnt64: 64-bit counter with per-half write enable and increment suppress.
- All other registers use the existing ysyx_23060025_Reg-style enable registers with async reset.

Test Plan:
- Reset mid-run, then read mstatus and mtvec -> 0x00001800 and MTVEC_RST; mcycle counts 0,1,2 on successive cycles after release.
- csr_op = RW mscratch 0xA5A5A5A5; RS 0x0000000F; RC 0x000000A0 -> reads return 0xA5A5A5A5, then 0xA5A5A5AF, then 0xA5A5A50F.
- Set MIE = 1 and MTIE = 1, raise irq_timer -> irq_pending = 1. Then trap_valid with cause 0x80000007 and pc 0x80000102 -> at the edge, mepc = 0x80000100, MIE = 0, MPIE = 1, irq_pending = 0; redirect_pc = mtvec in the trap cycle.
- mret_valid after that trap -> redirect_pc = 0x80000100, then MIE = 1 and MPIE = 1.
- trap_valid, mret_valid and RW mtvec 0x1234 in the same cycle -> only the trap is taken and mtvec is unchanged.
- RW mvendorid 0x1 -> csr_illegal = 1 and the value stays 0x79737978. Write mcycle = 0xFFFFFFFF with mcycleh = 0 -> next cycle low = 0 and high = 1.

Source files
------------

// File: rtl/ysyx_23060025_csr_file_pkg.sv
// Shared CSR addresses, operation encodings and field positions for the M-mode CSR file.
package ysyx_23060025_csr_file_pkg;

  localparam logic [11:0] CsrMstatus   = 12'h300;
  localparam logic [11:0] CsrMie       = 12'h304;
  localparam logic [11:0] CsrMtvec     = 12'h305;
  localparam logic [11:0] CsrMscratch  = 12'h340;
  localparam logic [11:0] CsrMepc      = 12'h341;
  localparam logic [11:0] CsrMcause    = 12'h342;
  localparam logic [11:0] CsrMip       = 12'h344;
  localparam logic [11:0] CsrMcycle    = 12'hB00;
  localparam logic [11:0] CsrMcycleh   = 12'hB80;
  localparam logic [11:0] CsrMvendorid = 12'hF11;
  localparam logic [11:0] CsrMarchid   = 12'hF12;

  typedef enum logic [1:0] {
    CsrOpNone = 2'b00,
    CsrOpRw   = 2'b01,
    CsrOpRs   = 2'b10,
    CsrOpRc   = 2'b11
  } csr_op_e;

  localparam int unsigned MstatusMie  = 3;
  localparam int unsigned MstatusMpie = 7;
  localparam int unsigned MieMtie     = 7;
  localparam int unsigned MipMtip     = 7;

  localparam logic [31:0] MstatusMppBits = 32'h0000_1800;

  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_v,
                                            input logic [31:0] wdata);
    logic [31:0] res;
    res = old_v;
    case (op)
      CsrOpRw: res = wdata;
      CsrOpRs: res = old_v | wdata;
      CsrOpRc: res = old_v & ~wdata;
      default: res = old_v;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ysyx_23060025_csr_cnt64.sv
// 64-bit free-running cycle counter; a write to either half loads it and holds the count.
module ysyx_23060025_csr_cnt64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 64'd1;
    if (wr_lo_i || wr_hi_i) begin
      cnt_d = cnt_q;
      if (wr_lo_i) cnt_d[31:0] = wdata_i;
      if (wr_hi_i) cnt_d[63:32] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx_23060025_csr_file.sv
// M-mode CSR file: CSRRW/RS/RC access, trap entry / MRET sequencing and timer-interrupt gating.
module ysyx_23060025_csr_file
  import ysyx_23060025_csr_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter bit          MCYCLE_EN     = 1'b1,
  parameter logic [31:0] MVENDORID_VAL = 32'h7973_7978,
  parameter logic [31:0] MARCHID_VAL   = 32'd23060025,
  parameter logic [31:0] MTVEC_RST     = 32'h0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [11:0]           csr_addr,
  input  logic [1:0]            csr_op,
  input  logic [DATA_WIDTH-1:0] csr_wdata,
  output logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  csr_illegal,
  input  logic                  trap_valid,
  input  logic [DATA_WIDTH-1:0] trap_cause,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  input  logic                  mret_valid,
  input  logic                  irq_timer,
  output logic                  irq_pending,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  csr_op_e     op;
  logic        st_mie_q, st_mie_d, st_mpie_q, st_mpie_d, mtie_q, mtie_d;
  logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d, mscratch_q, mscratch_d;
  logic [31:0] rdata, wval, mstatus_v;
  logic [63:0] cycle_cnt;
  logic        impl, ro, wr_req, wr_en;

  assign op        = csr_op_e'(csr_op);
  assign mstatus_v = MstatusMppBits | (32'(st_mpie_q) << MstatusMpie) | (32'(st_mie_q) << MstatusMie);

  always_comb begin
    rdata = '0;
    impl  = 1'b1;
    ro    = 1'b0;
    case (csr_addr)
      CsrMstatus:   rdata = mstatus_v;
      CsrMie:       rdata = 32'(mtie_q) << MieMtie;
      CsrMtvec:     rdata = mtvec_q;
      CsrMscratch:  rdata = mscratch_q;
      CsrMepc:      rdata = mepc_q;
      CsrMcause:    rdata = mcause_q;
      CsrMip:       begin rdata = 32'(irq_timer) << MipMtip; ro = 1'b1; end
      CsrMcycle:    begin rdata = cycle_cnt[31:0];  ro = !MCYCLE_EN; end
      CsrMcycleh:   begin rdata = cycle_cnt[63:32]; ro = !MCYCLE_EN; end
      CsrMvendorid: begin rdata = MVENDORID_VAL; ro = 1'b1; end
      CsrMarchid:   begin rdata = MARCHID_VAL;   ro = 1'b1; end
      default:      impl = 1'b0;
    endcase
  end

  // RS/RC with a zero operand are pure reads and must not trip the read-only check.
  assign wr_req      = (op == CsrOpRw) || ((op != CsrOpNone) && (csr_wdata != '0));
  assign csr_illegal = (op != CsrOpNone) && (!impl || (ro && wr_req));
  assign wr_en       = wr_req && impl && !ro && !trap_valid && !mret_valid;
  assign wval        = csr_apply(op, rdata, csr_wdata);
  assign csr_rdata   = rdata;

  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mtie_d     = mtie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mscratch_d = mscratch_q;
    if (trap_valid) begin
      mepc_d    = trap_pc & ~32'h3;
      mcause_d  = trap_cause;
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
    end else if (mret_valid) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        CsrMstatus:  begin st_mie_d = wval[MstatusMie]; st_mpie_d = wval[MstatusMpie]; end
        CsrMie:      mtie_d = wval[MieMtie];
        CsrMtvec:    mtvec_d = wval & ~32'h3;
        CsrMscratch: mscratch_d = wval;
        CsrMepc:     mepc_d = wval & ~32'h3;
        CsrMcause:   mcause_d = wval;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST & ~32'h3;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mscratch_q <= '0;
    end else begin
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mtie_q     <= mtie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mscratch_q <= mscratch_d;
    end
  end

  generate
    if (MCYCLE_EN) begin : g_mcycle
      ysyx_23060025_csr_cnt64 u_cnt64 (
        .clk_i   (clock),
        .rst_i   (reset),
        .wr_lo_i (wr_en && (csr_addr == CsrMcycle)),
        .wr_hi_i (wr_en && (csr_addr == CsrMcycleh)),
        .wdata_i (wval),
        .cnt_o   (cycle_cnt)
      );
    end else begin : g_no_mcycle
      assign cycle_cnt = '0;
    end
  endgenerate

  assign irq_pending    = st_mie_q && mtie_q && irq_timer;
  assign redirect_valid = trap_valid || mret_valid;
  assign redirect_pc    = trap_valid ? mtvec_q : mepc_q;

endmodule

// File: tb/tb_ysyx_23060025_csr_file.sv
// Table-driven bench for the CSR file; expectations flow through a scoreboard queue.
module tb_ysyx_23060025_csr_file;

  localparam logic [31:0] MtvecRst = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata, csr_rdata, trap_cause, trap_pc, redirect_pc;
  logic        csr_illegal, trap_valid, mret_valid, irq_timer, irq_pending, redirect_valid;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic        trap;
    logic [31:0] cause;
    logic [31:0] tpc;
    logic        mret;
    logic        irq;
    logic        chk_rd;
    logic [31:0] rd;
    logic        ill;
    logic        irqp;
    logic        rv;
    logic [31:0] rpc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  ysyx_23060025_csr_file #(
    .MTVEC_RST (MtvecRst)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .csr_addr       (csr_addr),
    .csr_op         (csr_op),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .csr_illegal    (csr_illegal),
    .trap_valid     (trap_valid),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .mret_valid     (mret_valid),
    .irq_timer      (irq_timer),
    .irq_pending    (irq_pending),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic add(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wdata,
                     input logic trap, input logic [31:0] cause, input logic [31:0] tpc,
                     input logic mret, input logic irq, input logic chk_rd,
                     input logic [31:0] rd, input logic ill, input logic irqp,
                     input logic [31:0] rpc);
    vec_t v;
    v.addr = addr; v.op = op; v.wdata = wdata; v.trap = trap; v.cause = cause; v.tpc = tpc;
    v.mret = mret; v.irq = irq; v.chk_rd = chk_rd; v.rd = rd; v.ill = ill; v.irqp = irqp;
    v.rv = trap | mret; v.rpc = rpc;
    tbl.push_back(v);
  endtask

  task automatic rd_row(input logic [11:0] addr, input logic irq, input logic [31:0] rd,
                        input logic irqp);
    add(addr, 2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, irq, 1'b1, rd, 1'b0, irqp, 32'h0);
  endtask

  task automatic wr_row(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wdata,
                        input logic [31:0] rd, input logic ill);
    add(addr, op, wdata, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, rd, ill, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; csr_addr = 12'h300; csr_op = 2'b00; csr_wdata = '0;
    trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; mret_valid = 1'b0; irq_timer = 1'b0;

    // mcycle after release, then mscratch RW/RS/RC
    rd_row(12'hB00, 0, 32'd0, 0);
    rd_row(12'hB00, 0, 32'd1, 0);
    rd_row(12'hB00, 0, 32'd2, 0);
    rd_row(12'h300, 0, 32'h0000_1800, 0);
    rd_row(12'h305, 0, MtvecRst, 0);
    wr_row(12'h340, 2'b01, 32'hA5A5_A5A5, 32'h0, 0);
    wr_row(12'h340, 2'b10, 32'h0000_000F, 32'hA5A5_A5A5, 0);
    wr_row(12'h340, 2'b11, 32'h0000_00A0, 32'hA5A5_A5AF, 0);
    rd_row(12'h340, 0, 32'hA5A5_A50F, 0);
    // enable MIE and MTIE, then timer interrupt, trap, mret
    wr_row(12'h300, 2'b10, 32'h0000_0008, 32'h0000_1800, 0);
    wr_row(12'h304, 2'b01, 32'hFFFF_FFFF, 32'h0, 0);
    rd_row(12'h304, 0, 32'h0000_0080, 0);
    rd_row(12'h300, 1, 32'h0000_1808, 1);
    rd_row(12'h344, 1, 32'h0000_0080, 1);
    add(12'h300, 2'b00, 32'h0, 1, 32'h8000_0007, 32'h8000_0102, 0, 1, 1, 32'h0000_1808, 0, 1,
        MtvecRst);
    rd_row(12'h300, 1, 32'h0000_1880, 0);
    rd_row(12'h341, 0, 32'h8000_0100, 0);
    rd_row(12'h342, 0, 32'h8000_0007, 0);
    add(12'h341, 2'b00, 32'h0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h8000_0100, 0, 0, 32'h8000_0100);
    rd_row(12'h300, 1, 32'h0000_1888, 1);
    // trap + mret + mtvec write in one cycle: trap only
    add(12'h305, 2'b01, 32'h0000_1234, 1, 32'h2, 32'h0000_0043, 1, 0, 1, MtvecRst, 0, 0,
        MtvecRst);
    rd_row(12'h305, 0, MtvecRst, 0);
    rd_row(12'h300, 0, 32'h0000_1880, 0);
    rd_row(12'h341, 0, 32'h0000_0040, 0);
    // read-only and unimplemented accesses
    wr_row(12'hF11, 2'b01, 32'h1, 32'h7973_7978, 1);
    rd_row(12'hF11, 0, 32'h7973_7978, 0);
    wr_row(12'hF11, 2'b10, 32'h0, 32'h7973_7978, 0);
    wr_row(12'hF12, 2'b11, 32'h0, 32'd23060025, 0);
    wr_row(12'h344, 2'b11, 32'h80, 32'h0, 1);
    wr_row(12'h7C0, 2'b01, 32'h5, 32'h0, 1);
    // low-bit masking on mepc/mtvec
    wr_row(12'h341, 2'b01, 32'h1234_5677, 32'h0000_0040, 0);
    rd_row(12'h341, 0, 32'h1234_5674, 0);
    wr_row(12'h305, 2'b01, 32'h0000_1237, MtvecRst, 0);
    rd_row(12'h305, 0, 32'h0000_1234, 0);
    // mcycle carry into mcycleh
    wr_row(12'hB80, 2'b01, 32'h0, 32'h0, 0);
    add(12'hB00, 2'b01, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    rd_row(12'hB00, 0, 32'hFFFF_FFFF, 0);
    rd_row(12'hB00, 0, 32'h0, 0);
    rd_row(12'hB80, 0, 32'h1, 0);

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v, e;
      v = tbl[i];
      csr_addr = v.addr; csr_op = v.op; csr_wdata = v.wdata; trap_valid = v.trap;
      trap_cause = v.cause; trap_pc = v.tpc; mret_valid = v.mret; irq_timer = v.irq;
      sb.push_back(v);
      #4;
      e = sb.pop_front();
      if (e.chk_rd) chk($sformatf("row%0d rdata", i), csr_rdata, e.rd);
      chk($sformatf("row%0d illegal", i), 32'(csr_illegal), 32'(e.ill));
      chk($sformatf("row%0d irq_pending", i), 32'(irq_pending), 32'(e.irqp));
      chk($sformatf("row%0d redirect_valid", i), 32'(redirect_valid), 32'(e.rv));
      if (e.rv) chk($sformatf("row%0d redirect_pc", i), redirect_pc, e.rpc);
      @(posedge clock);
      #1;
    end

    // asynchronous reset mid-cycle: values apply immediately
    csr_op = 2'b00; csr_wdata = '0; mret_valid = 1'b0; irq_timer = 1'b1;
    csr_addr = 12'h300; trap_valid = 1'b1;
    #2 reset = 1'b1;
    #1 chk("rst mstatus", csr_rdata, 32'h0000_1800);
    chk("rst redirect_valid", 32'(redirect_valid), 32'h1);
    chk("rst redirect_pc", redirect_pc, MtvecRst);
    chk("rst irq_pending", 32'(irq_pending), 32'h0);
    csr_addr = 12'h340;
    #1 chk("rst mscratch", csr_rdata, 32'h0);
    csr_addr = 12'h304;
    #1 chk("rst mie", csr_rdata, 32'h0);
    csr_addr = 12'hB00;
    trap_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    #3 chk("post-rst mcycle0", csr_rdata, 32'd0);
    @(posedge clock);
    #3 chk("post-rst mcycle1", csr_rdata, 32'd1);
    @(posedge clock);
    #3 chk("post-rst mcycle2", csr_rdata, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
